// File: rtl/bat_pkg.sv
// Shared constants for the bat register bank: data width, register indices
// and the per-register RW strobe encoding.
package bat_pkg;

  localparam int DATA_W = 8;

  localparam int REG_A   = 0;
  localparam int REG_B   = 1;
  localparam int REG_OUT = 7;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/bat_out_fifo.sv
// Small synchronous FIFO for the OUT port: occupancy counter plus wrapping
// read/write pointers. A push while full is ignored unless a pop frees a slot.
module bat_out_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_data,
  output logic              o_full,
  output logic              o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              w_do_push;
  logic              w_do_pop;

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_data    = r_mem[r_rd_ptr];

  // NOTE: storage has no reset; the counter alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/bat_register_file.sv
// General-purpose register bank with bus read/write, A/B taps and a valid/ready
// OUT port. Define BAT_OUT_FIFO_EN to queue OUT writes in an OUT_DEPTH-entry FIFO.
module bat_register_file #(
  parameter int DATA_W    = bat_pkg::DATA_W,
  parameter int NUM_REGS  = 8,
  parameter int OUT_DEPTH = 4
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [NUM_REGS-1:0] REGS_INC,
  input  logic [NUM_REGS-1:0] REGS_RW,
  input  logic [NUM_REGS-1:0] REGS_EN,
  input  logic [DATA_W-1:0]   BUS_IN,
  output logic [DATA_W-1:0]   BUS_OUT,
  output logic                BUS_DRIVE,
  output logic                BUS_CONFLICT,
  output logic [DATA_W-1:0]   A_VAL,
  output logic [DATA_W-1:0]   B_VAL,
  output logic [DATA_W-1:0]   OUT_DATA,
  output logic                OUT_VALID,
  input  logic                OUT_READY,
  output logic                OUT_OVERFLOW
);

  import bat_pkg::*;

  localparam int OUT_IDX = NUM_REGS - 1;

  if (OUT_DEPTH < 2 || (OUT_DEPTH & (OUT_DEPTH - 1)) != 0) begin : g_bad_out_depth
    $error("OUT_DEPTH must be a power of two and at least 2");
  end

  logic [DATA_W-1:0]   r_regs [NUM_REGS];
  logic [NUM_REGS-1:0] w_rd;
  logic [NUM_REGS-1:0] w_ld;
  logic [NUM_REGS-1:0] w_inc;
  logic                w_out_wr;
  logic                w_out_lost;
  logic                r_out_overflow;

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      w_rd[i]  = REGS_EN[i] && (REGS_RW[i] == RW_READ);
      w_ld[i]  = REGS_EN[i] && (REGS_RW[i] == RW_WRITE);
      w_inc[i] = REGS_INC[i] && (REGS_RW[i] == RW_WRITE) && !REGS_EN[i];
    end
  end

  // NOTE: default assignment first, so no path leaves BUS_OUT unassigned (no latch).
  always_comb begin
    BUS_OUT = '0;
    for (int i = NUM_REGS - 1; i >= 0; i--) begin
      if (w_rd[i]) BUS_OUT = r_regs[i];
    end
  end

  assign BUS_DRIVE    = |w_rd;
  assign BUS_CONFLICT = (w_rd & (w_rd - NUM_REGS'(1))) != '0;
  assign A_VAL        = r_regs[REG_A];
  assign B_VAL        = r_regs[REG_B];
  assign w_out_wr     = w_ld[OUT_IDX] || w_inc[OUT_IDX];

  // Load has priority over increment by construction of w_inc.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_ld[i])       r_regs[i] <= BUS_IN;
        else if (w_inc[i]) r_regs[i] <= r_regs[i] + DATA_W'(1);
      end
    end
  end

`ifdef BAT_OUT_FIFO_EN
  logic [DATA_W-1:0] w_out_next;
  logic [DATA_W-1:0] w_fifo_head;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic              w_pop;

  assign w_out_next = w_ld[OUT_IDX] ? BUS_IN : r_regs[OUT_IDX] + DATA_W'(1);
  assign w_pop      = OUT_VALID && OUT_READY;

  bat_out_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (OUT_DEPTH)
  ) u_out_fifo (
    .clk     (CLK),
    .rst_n   (RST),
    .i_push  (w_out_wr),
    .i_data  (w_out_next),
    .i_pop   (w_pop),
    .o_data  (w_fifo_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  assign OUT_VALID  = !w_fifo_empty;
  assign OUT_DATA   = w_fifo_empty ? '0 : w_fifo_head;
  assign w_out_lost = w_out_wr && w_fifo_full && !w_pop;
`else
  logic r_out_valid;

  // A fresh write keeps the value pending even on the edge that delivers the old one.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)           r_out_valid <= 1'b0;
    else if (w_out_wr)  r_out_valid <= 1'b1;
    else if (OUT_READY) r_out_valid <= 1'b0;
  end

  assign OUT_VALID  = r_out_valid;
  assign OUT_DATA   = r_regs[OUT_IDX];
  assign w_out_lost = w_out_wr && r_out_valid && !OUT_READY;
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_out_overflow <= 1'b0;
    else      r_out_overflow <= r_out_overflow || w_out_lost;
  end

  assign OUT_OVERFLOW = r_out_overflow;

endmodule
